// File: rtl/unary_pkg.sv
// Shared definitions for the unary encode/decode blocks: FSM state type and
// window/count sizing helpers.
package unary_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Cycles per unary window for a given magnitude width.
  function automatic int window_len(input int size);
    return (1 << size) + 2;
  endfunction

  // Counter width able to hold every count 0..window without wrapping.
  function automatic int count_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/unary_lane_counter.sv
// One unary lane: accumulates ones over a window, holds the sampled sign and
// presents the saturated two's-complement value of the final count.
module unary_lane_counter
  import unary_pkg::*;
#(
  parameter int BIT_WIDTH = 5,
  parameter int SIZE      = BIT_WIDTH - 1,
  parameter int WINDOW    = window_len(SIZE)
) (
  input  logic                        clk,
  input  logic                        load,
  input  logic                        count_en,
  input  logic                        unary_bit,
  input  logic                        sign_bit,
  output logic signed [BIT_WIDTH-1:0] result,
  output logic                        sat
);

  localparam int            CW      = count_width(WINDOW);
  localparam logic [CW-1:0] MAX_MAG = CW'((1 << SIZE) - 1);

  logic [CW-1:0] count;
  logic          sign;
  logic [CW-1:0] final_count;

  // Clamp a raw count to the largest representable magnitude.
  function automatic logic [SIZE-1:0] sat_mag(input logic [CW-1:0] c);
    if (c > MAX_MAG) begin
      return {SIZE{1'b1}};
    end
    return c[SIZE-1:0];
  endfunction

  // Apply sign to a magnitude; a zero magnitude stays zero when negated.
  function automatic logic signed [BIT_WIDTH-1:0] apply_sign(input logic [SIZE-1:0] m,
                                                             input logic            s);
    logic signed [BIT_WIDTH-1:0] v;
    v = signed'(BIT_WIDTH'(m));
    return s ? -v : v;
  endfunction

  // Window accumulator: a window open reloads with this cycle's bit and sign.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= CW'(unary_bit);
      sign  <= sign_bit;
    end else if (count_en) begin
      count <= count + CW'(unary_bit);
    end
  end

  // The final count includes the bit arriving in the window's last cycle.
  assign final_count = count + CW'(unary_bit);
  assign sat         = (final_count > MAX_MAG);
  assign result      = apply_sign(sat_mag(final_count), sign);

endmodule

// File: rtl/unary_stream_decoder.sv
// Converts per-lane unary pulse streams into signed binary words over a fixed
// window opened by frame_start, with a valid/ready output register and sticky
// overrun / framing error flags.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int BIT_WIDTH = 5,
  parameter int SIZE      = BIT_WIDTH - 1,
  parameter int LANES     = 2,
  parameter int WINDOW    = window_len(SIZE)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_start,
  input  logic [LANES-1:0]                  unary_in,
  input  logic [LANES-1:0]                  sign_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0][BIT_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]                  out_sat,
  output logic                              busy,
  output logic                              overrun,
  output logic                              frame_err
);

  localparam int            WW       = $clog2(WINDOW);
  localparam logic [WW-1:0] LAST_POS = WW'(WINDOW - 1);

  state_t                          state;
  logic [WW-1:0]                   wcnt;
  logic                            counting;
  logic                            last;
  logic                            accept;
  logic [LANES-1:0][BIT_WIDTH-1:0] lane_result;
  logic [LANES-1:0]                lane_sat;

  // wcnt is the position of the current cycle inside the window; the
  // frame_start cycle is position 0, so the window closes at WINDOW-1.
  assign counting = (state == COUNT);
  assign last     = counting && (wcnt == LAST_POS);
  assign accept   = out_valid && out_ready;
  assign busy     = counting;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    unary_lane_counter #(
      .BIT_WIDTH (BIT_WIDTH),
      .SIZE      (SIZE),
      .WINDOW    (WINDOW)
    ) u_lane (
      .clk       (clk),
      .load      (frame_start),
      .count_en  (counting),
      .unary_bit (unary_in[i]),
      .sign_bit  (sign_in[i]),
      .result    (lane_result[i]),
      .sat       (lane_sat[i])
    );
  end

  // Window FSM, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Output register: a finished window loads only if the slot is free or
      // being drained this cycle; otherwise the new result is dropped.
      if (last) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= lane_result;
          out_sat   <= lane_sat;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= COUNT;
            wcnt  <= WW'(1);
          end
        end
        COUNT: begin
          if (frame_start) begin
            // A new window opening exactly on the closing cycle is a legal
            // back-to-back start; anywhere else it aborts the partial window.
            wcnt <= WW'(1);
            if (!last) begin
              frame_err <= 1'b1;
            end
          end else if (last) begin
            state <= IDLE;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder with a result scoreboard.
module tb_unary_stream_decoder;

  localparam int BW  = 5;
  localparam int LN  = 2;
  localparam int WIN = 18;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   frame_start = 1'b0;
  logic [LN-1:0]          unary_in = '0;
  logic [LN-1:0]          sign_in = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [LN-1:0][BW-1:0]  out_data;
  logic [LN-1:0]          out_sat;
  logic                   busy;
  logic                   overrun;
  logic                   frame_err;

  int checks = 0;
  int errors = 0;

  // Expected results as {out_sat, out_data[1], out_data[0]}.
  logic [11:0] exp_q[$];

  unary_stream_decoder #(
    .BIT_WIDTH (BW),
    .LANES     (LN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .unary_in    (unary_in),
    .sign_in     (sign_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .busy        (busy),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, then move just past the capturing edge.
  task automatic step(input logic fs, input logic [LN-1:0] u, input logic [LN-1:0] s);
    frame_start = fs;
    unary_in    = u;
    sign_in     = s;
    @(posedge clk);
    #1;
  endtask

  // One full window: lane i sees n_i leading ones; sign is valid only on the
  // opening cycle, its inverse is driven elsewhere to prove it is ignored.
  task automatic run_window(input logic [LN-1:0] s, input int n0, input int n1,
                            input bit chk_idle);
    for (int k = 0; k < WIN; k++) begin
      step(k == 0, {logic'(k < n1), logic'(k < n0)}, (k == 0) ? s : ~s);
      if (chk_idle && k < WIN - 1) check("no_early_valid", out_valid, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b11, 2'b11);
  endtask

  // Scoreboard monitor: every accepted output must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %0h required none at %0t",
                 {out_sat, out_data}, $time);
      end else begin
        check("result", {20'd0, out_sat, out_data}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    step(1'b1, 2'b11, 2'b11);
    step(1'b0, 2'b00, 2'b00);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Basic: +7 on lane0, -3 on lane1
    exp_q.push_back({2'b00, 5'b11101, 5'b00111});
    run_window(2'b10, 7, 3, 1'b1);
    check("basic_valid_at_t18", out_valid, 1);
    check("basic_busy_done", busy, 0);
    idle(3);

    // Saturation on lane0, negative zero on lane1
    exp_q.push_back({2'b01, 5'b00000, 5'b01111});
    run_window(2'b10, 18, 0, 1'b1);
    check("sat_valid", out_valid, 1);
    idle(3);

    // Back-to-back windows: 5 then 9
    exp_q.push_back({2'b00, 5'd0, 5'd5});
    exp_q.push_back({2'b00, 5'd0, 5'd9});
    run_window(2'b00, 5, 0, 1'b1);
    check("b2b_valid_t18", out_valid, 1);
    check("b2b_busy_gap", busy, 0);
    run_window(2'b00, 9, 0, 1'b1);
    check("b2b_valid_t36", out_valid, 1);
    check("b2b_frame_err", frame_err, 0);
    check("b2b_overrun", overrun, 0);
    idle(3);

    // Backpressure: 4 is held, 6 is dropped
    out_ready = 1'b0;
    exp_q.push_back({2'b00, 5'd0, 5'd4});
    run_window(2'b00, 4, 0, 1'b1);
    check("bp_valid_first", out_valid, 1);
    check("bp_overrun_before", overrun, 0);
    run_window(2'b00, 6, 0, 1'b0);
    check("bp_valid_held", out_valid, 1);
    check("bp_data_held", out_data[0], 4);
    check("bp_overrun", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_cleared", out_valid, 0);
    idle(4);
    check("bp_queue_drained", exp_q.size(), 0);

    // Mid-window restart at t+5; only the restarted window yields a result
    for (int k = 0; k < 5; k++) step(k == 0, 2'b11, 2'b00);
    check("restart_frame_err_clear", frame_err, 0);
    exp_q.push_back({2'b00, 5'd0, 5'd3});
    run_window(2'b00, 3, 0, 1'b1);
    check("restart_frame_err", frame_err, 1);
    check("restart_valid_t23", out_valid, 1);
    idle(3);

    // Reset mid-window at t+10
    for (int k = 0; k < 10; k++) step(k == 0, 2'b11, 2'b00);
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    step(1'b0, 2'b11, 2'b00);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_sat", out_sat, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_frame_err", frame_err, 0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 2'b11, 2'b11);
      check("midrst_no_valid", out_valid, 0);
    end
    check("midrst_stays_idle", busy, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_stream_decoder.md
# unary_stream_decoder

- Converts per-lane unary (pulse-count) streams, such as the comparator-generated rate streams feeding the systolic array, back into signed two's-complement binary words.
- Counts ones over a fixed window of cycles that opens on `frame_start`, applies the per-lane sign sampled at window open, saturates, and presents the result on a valid/ready output register.
- Sits at the boundary where unary-domain data returns to binary logic: readback and loopback checking of encoded operands, and binary reconstruction of unary results.

## Interface
- `BIT_WIDTH`, 5, output word width (two's complement)
- `SIZE`, `BIT_WIDTH-1`, magnitude bits; maximum magnitude is (1<<SIZE)-1
- `LANES`, 2, independent unary lanes
- `WINDOW`, (1<<SIZE)+2, cycles per window; matches the encoder data-clock period
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `frame_start`  in  1  window opens this cycle; this cycle's bits are counted
- `unary_in`  in  [LANES-1:0]  one unary bit per lane per cycle
- `sign_in`  in  [LANES-1:0]  per-lane sign; sampled only on `frame_start` cycles
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`
- `out_data`  out  [LANES-1:0][BIT_WIDTH-1:0]  two's-complement results
- `out_sat`  out  [LANES-1:0]  lane count exceeded (1<<SIZE)-1 and was clamped
- `busy`  out  1  window in progress
- `overrun`  out  1  sticky: a result was discarded because the output was still pending
- `frame_err`  out  1  sticky: `frame_start` arrived mid-window

## Operation
- FSM states and transitions:
  - IDLE: `frame_start` → COUNT.
  - COUNT: the window counter `wcnt` runs 0..WINDOW-1.
  - At `wcnt==WINDOW-1`, the result is produced. The FSM then goes to IDLE, or stays in COUNT with `wcnt`=0 if `frame_start` is high in that same cycle (back-to-back windows, no frame error).
- Lane count:
  - On `frame_start`, count := `unary_in[i]` and the sign register := `sign_in[i]`.
  - Otherwise, while in COUNT, count += `unary_in[i]`.
  - Count width is `$clog2(WINDOW+1)`; the counter itself never wraps.
- Result:
  - mag = min(final count including the last-cycle bit, (1<<SIZE)-1); `out_sat[i]` = (final count > (1<<SIZE)-1).
  - `out_data[i]` = sign ? -mag : mag. Sign with mag 0 yields 0 (no negative zero).
- Output register:
  - Loads on result production if `out_valid==0`, or if `out_valid & out_ready` in that cycle (accept and reload in the same cycle).
  - Otherwise the new result is dropped, the held result is unchanged, and `overrun` sets.
- `out_valid` clears on accept unless a reload occurs in the same cycle.
- `frame_start` in COUNT with `wcnt` != WINDOW-1:
  - `frame_err` sets.
  - The window restarts: `wcnt`=0, counts reloaded, signs resampled. The partial window produces no result.
- `busy` = (state==COUNT).

## Timing
- Reset state of all outputs: 0. Sticky flags clear only on `reset`.
- `frame_start` at cycle t: bits from cycles t..t+WINDOW-1 are counted. `out_valid` rises at t+WINDOW; latency is WINDOW cycles.
- Back-to-back windows give one result every WINDOW cycles, with full throughput when `out_ready` is held high.
- `unary_in` outside COUNT and not on a `frame_start` cycle is ignored.
- `sign_in` on non-`frame_start` cycles is ignored.
- `reset` mid-window: next cycle is IDLE with all outputs 0. No result is ever produced for the aborted window.
- `reset` has priority over `frame_start` in the same cycle.

## Structure
- Shared package `unary_pkg`: FSM state enum (IDLE, COUNT), a `window_len(size)` function returning (1<<size)+2, and a count-width helper. Both the encoder side and this decoder import the package.
- Sub-module `unary_lane_counter`, one instance per lane: holds the count register, the sign register, saturation and sign conversion. The top level holds the FSM, `wcnt`, the output register and the sticky flags.

## Test plan
Defaults for all scenarios: BIT_WIDTH=5, LANES=2, WINDOW=18.
- Basic conversion: lane0 sign 0 with 7 ones; lane1 sign 1 with 3 ones; `out_ready`=1. Required: `out_valid` at t+18, `out_data` = {5'b11101, 5'b00111}, `out_sat` = 0.
- Saturation and negative zero: lane0 all 18 ones, sign 0; lane1 zero ones, sign 1. Required: lane0 = 15 with `out_sat[0]`=1; lane1 = 0.
- Back-to-back windows: `frame_start` at t and t+18 with lane0 counts 5 then 9. Required: results 5 then 9, `out_valid` at t+18 and t+36, `frame_err`=0.
- Backpressure: `out_ready`=0 across two back-to-back windows with counts 4 then 6. Required: `out_data` holds 4, `overrun`=1; after `out_ready`=1 the value 4 is accepted and no 6 ever appears.
- Mid-window restart: `frame_start` at t and again at t+5; 3 ones after t+5. Required: `frame_err`=1, result 3 at t+23, no result at t+18.
- Reset mid-window: `reset` at t+10. Required: at t+11 `busy`=0 and all outputs 0; `out_valid` stays 0 through t+30.
